// File: rtl/serial_parity_tx_pkg.sv
// Shared types and defaults for the serial parity transmitter.
// Holds the frame-state encoding and the default frame geometry.
package serial_parity_tx_pkg;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Counter width that stays legal when the count range is a single value.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_parity_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each serial bit. restart realigns the count to a new frame.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick = enable && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (restart || !enable || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_parity_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB-first, even parity, stop.
// Accepts a new word in the last stop cycle so frames can run back to back.
//
//   state  | meaning
//   IDLE   | line high, ready for a word
//   START  | driving the start bit (0)
//   DATA   | shifting data bits out LSB-first
//   PARITY | driving the even-parity bit
//   STOP   | driving the stop bit (1); last cycle may accept the next word
module serial_parity_tx
  import serial_parity_tx_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic              parity_q;
  logic              parity_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  bit_idx_nxt;
  logic              serial_nxt;
  logic              bit_tick;
  logic              accept;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (busy),
    .restart  (accept),
    .bit_tick (bit_tick)
  );

  assign busy       = (state != IDLE);
  assign ready_out  = (state == IDLE) || ((state == STOP) && bit_tick);
  // reset wins over a coincident handshake and suppresses the done pulse
  assign accept     = valid_in && ready_out && !reset;
  assign frame_done = (state == STOP) && bit_tick && !reset;

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    parity_nxt  = parity_q;
    bit_idx_nxt = bit_idx;
    serial_nxt  = 1'b1;

    case (state)
      IDLE: begin
      end
      START: begin
        if (bit_tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_IDX) begin
            state_nxt = PARITY;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
            shift_nxt   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
      STOP: begin
        if (bit_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (accept) begin
      state_nxt   = START;
      shift_nxt   = data_in;
      parity_nxt  = ^data_in;
      bit_idx_nxt = '0;
    end

    // line level is decoded from next-state values so serial_out is a flop
    case (state_nxt)
      IDLE:    serial_nxt = 1'b1;
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      PARITY:  serial_nxt = parity_nxt;
      STOP:    serial_nxt = 1'b1;
      default: serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx    <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      parity_q   <= parity_nxt;
      bit_idx    <= bit_idx_nxt;
      serial_out <= serial_nxt;
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Directed bench for serial_parity_tx: one instance at 1 clk/bit, one at 4.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_parity_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       reset1, valid1, ready1, ser1, busy1, done1;
  logic [7:0] data1;
  logic       reset4, valid4, ready4, ser4, busy4, done4;
  logic [7:0] data4;

  serial_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .reset      (reset1),
    .data_in    (data1),
    .valid_in   (valid1),
    .ready_out  (ready1),
    .serial_out (ser1),
    .busy       (busy1),
    .frame_done (done1)
  );

  serial_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .reset      (reset4),
    .data_in    (data4),
    .valid_in   (valid4),
    .ready_out  (ready4),
    .serial_out (ser4),
    .busy       (busy4),
    .frame_done (done4)
  );

  task automatic test_reset();
    reset1 = 1'b1; valid1 = 1'b0; data1 = 8'h00;
    reset4 = 1'b1; valid4 = 1'b0; data4 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ser1 !== 1'b1) begin n_fail++; $display("FAIL reset_serial1: got %b want 1", ser1); end
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b want 1", ready1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b want 0", done1); end
    n_checks++; if (ser4 !== 1'b1) begin n_fail++; $display("FAIL reset_serial4: got %b want 1", ser4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    reset1 = 1'b0; reset4 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ser1 !== 1'b1) begin n_fail++; $display("FAIL idle_serial1: got %b want 1", ser1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL idle_busy1: got %b want 0", busy1); end
    n_checks++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL idle_ready4: got %b want 1", ready4); end
  endtask

  task automatic test_frame_a5();
    logic [10:0] exp;
    logic e, ed;
    exp = 11'b10101001010;
    @(negedge clk);
    data1 = 8'hA5; valid1 = 1'b1;
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL a5_ready_pre: got %b want 1", ready1); end
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0; data1 = 8'h00;
    for (int c = 1; c <= 11; c++) begin
      e  = exp[c-1];
      ed = (c == 11);
      n_checks++; if (ser1 !== e) begin n_fail++; $display("FAIL a5_serial c%0d: got %b want %b", c, ser1, e); end
      n_checks++; if (done1 !== ed) begin n_fail++; $display("FAIL a5_done c%0d: got %b want %b", c, done1, ed); end
      n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL a5_busy c%0d: got %b want 1", c, busy1); end
      @(negedge clk);
    end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end: got %b want 0", busy1); end
    n_checks++; if (ser1 !== 1'b1) begin n_fail++; $display("FAIL a5_serial_end: got %b want 1", ser1); end
  endtask

  task automatic test_frame_07();
    logic [10:0] exp;
    logic e;
    exp = 11'b11000001110;
    @(negedge clk);
    data1 = 8'h07; valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      e = exp[c-1];
      n_checks++; if (ser1 !== e) begin n_fail++; $display("FAIL 07_serial c%0d: got %b want %b", c, ser1, e); end
      @(negedge clk);
    end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL 07_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_ignore_inputs();
    logic [10:0] exp;
    logic e, er;
    exp = 11'b10001111000;
    @(negedge clk);
    data1 = 8'h3C; valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      e  = exp[c-1];
      er = (c == 11);
      n_checks++; if (ser1 !== e) begin n_fail++; $display("FAIL ign_serial c%0d: got %b want %b", c, ser1, e); end
      n_checks++; if (ready1 !== er) begin n_fail++; $display("FAIL ign_ready c%0d: got %b want %b", c, ready1, er); end
      if (c <= 9) begin
        valid1 = c[0];
        data1  = 8'($urandom);
      end else begin
        valid1 = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ign_busy_c12: got %b want 0", busy1); end
    @(negedge clk);
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ign_busy_c13: got %b want 0", busy1); end
    n_checks++; if (ser1 !== 1'b1) begin n_fail++; $display("FAIL ign_serial_c13: got %b want 1", ser1); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    logic e, eh;
    exp = {11'b11100000000, 11'b11000000010};
    @(negedge clk);
    data1 = 8'h01; valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 22; c++) begin
      e  = exp[c-1];
      eh = (c == 11) || (c == 22);
      n_checks++; if (ser1 !== e) begin n_fail++; $display("FAIL b2b_serial c%0d: got %b want %b", c, ser1, e); end
      n_checks++; if (ready1 !== eh) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", c, ready1, eh); end
      n_checks++; if (done1 !== eh) begin n_fail++; $display("FAIL b2b_done c%0d: got %b want %b", c, done1, eh); end
      n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b want 1", c, busy1); end
      if (c == 1)  data1  = 8'h80;
      if (c == 12) valid1 = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy1); end
    n_checks++; if (ser1 !== 1'b1) begin n_fail++; $display("FAIL b2b_serial_end: got %b want 1", ser1); end
  endtask

  task automatic test_slow_ff();
    logic e, ed;
    @(negedge clk);
    data4 = 8'hFF; valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid4 = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      if (c <= 4)       e = 1'b0;
      else if (c <= 36) e = 1'b1;
      else if (c <= 40) e = 1'b0;
      else              e = 1'b1;
      ed = (c == 44);
      n_checks++; if (ser4 !== e) begin n_fail++; $display("FAIL slow_serial c%0d: got %b want %b", c, ser4, e); end
      n_checks++; if (done4 !== ed) begin n_fail++; $display("FAIL slow_done c%0d: got %b want %b", c, done4, ed); end
      n_checks++; if (ready4 !== ed) begin n_fail++; $display("FAIL slow_ready c%0d: got %b want %b", c, ready4, ed); end
      @(negedge clk);
    end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL slow_busy_end: got %b want 0", busy4); end
    n_checks++; if (ser4 !== 1'b1) begin n_fail++; $display("FAIL slow_serial_end: got %b want 1", ser4); end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] exp;
    logic e;
    exp = 5'b01010;
    @(negedge clk);
    data1 = 8'h55; valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e = exp[c-1];
      n_checks++; if (ser1 !== e) begin n_fail++; $display("FAIL rst_serial c%0d: got %b want %b", c, ser1, e); end
      if (c == 5) begin
        reset1 = 1'b1;
        valid1 = 1'b1;
        data1  = 8'hFF;
      end
      @(negedge clk);
    end
    n_checks++; if (ser1 !== 1'b1) begin n_fail++; $display("FAIL rst_serial_after: got %b want 1", ser1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after: got %b want 0", busy1); end
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", ready1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL rst_done_after: got %b want 0", done1); end
    reset1 = 1'b0;
    valid1 = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL rst_no_done c%0d: got %b want 0", c, done1); end
      n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_no_frame c%0d: got %b want 0", c, busy1); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset1 = 1'b1; valid1 = 1'b0; data1 = 8'h00;
    reset4 = 1'b1; valid4 = 1'b0; data4 = 8'h00;
    test_reset();
    test_frame_a5();
    test_frame_07();
    test_ignore_inputs();
    test_back_to_back();
    test_slow_ff();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
